// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with a bounded burst length, steering the
// winning requester's word into a registered valid/ready output stage.
module rr_mux_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  input  logic [W-1:0] req_data0,
  input  logic [W-1:0] req_data1,
  input  logic [W-1:0] req_data2,
  input  logic [W-1:0] req_data3,
  output logic [3:0]   req_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST);

  logic [1:0]    last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    grant;
  logic [1:0]    idx;
  logic          gnt;
  logic          keep;
  logic          load_en;
  logic [W-1:0]  mux_data;

  // cnt==0 means no burst is in progress, so the scan restarts after last.
  always_comb begin
    load_en = !out_valid || out_ready;
    keep    = (cnt != '0) && (cnt < CMAX) && req_valid[last];
    gnt     = 1'b0;
    grant   = last;
    cnt_nxt = '0;
    idx     = last;
    if (keep) begin
      gnt     = 1'b1;
      grant   = last;
      cnt_nxt = cnt + CW'(1);
    end else begin
      for (int unsigned k = 1; k <= 4; k++) begin
        idx = last + 2'(k);
        if (!gnt && req_valid[idx]) begin
          gnt     = 1'b1;
          grant   = idx;
          cnt_nxt = CW'(1);
        end
      end
    end
  end

  always_comb begin
    case (grant)
      2'd0:    mux_data = req_data0;
      2'd1:    mux_data = req_data1;
      2'd2:    mux_data = req_data2;
      default: mux_data = req_data3;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (gnt && load_en && !rst) begin
      req_ready = 4'b0001 << grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= 2'd3;
      cnt       <= '0;
    end else if (load_en) begin
      if (gnt) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_sel   <= grant;
        last      <= grant;
        cnt       <= cnt_nxt;
      end else begin
        out_valid <= 1'b0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: two instances (MAX_BURST 2 and 1) share
// stimulus; a reference arbiter predicts grants, a monitor checks accepted words.
module tb_rr_mux_arbiter;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         out_ready;
  logic [3:0]   req_valid;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   rdy [2];
  logic         ov  [2];
  logic [W-1:0] od  [2];
  logic [1:0]   os  [2];

  rr_mux_arbiter #(.W(W), .MAX_BURST(2)) u_b2 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
    .req_ready(rdy[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_sel(os[0])
  );

  rr_mux_arbiter #(.W(W), .MAX_BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_data0(d0), .req_data1(d1), .req_data2(d2), .req_data3(d3),
    .req_ready(rdy[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_sel(os[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    acc0[$];
  int    acc1[$];
  int    checks = 0;
  int    errors = 0;
  int    mv[2];
  int    mlast[2];
  int    mcnt[2];
  int    maxb[2] = '{2, 1};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbiter: continue the current burst if allowed, else first valid
  // requester found walking forward from the previous winner.
  function automatic int pick(input logic [3:0] v, input int lst, input int cnt,
                              input int mb, output bit cont);
    cont = 1'b0;
    if (cnt > 0 && cnt < mb && v[lst]) begin
      cont = 1'b1;
      return lst;
    end
    for (int k = 1; k <= 4; k++) begin
      if (v[(lst + k) % 4]) return (lst + k) % 4;
    end
    return -1;
  endfunction

  task automatic cycle(input logic r, input logic [3:0] v,
                       input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic [W-1:0] a2, input logic [W-1:0] a3,
                       input logic ordy);
    int           g[2];
    bit           cont[2];
    bit           ld[2];
    logic [3:0]   exp_rdy;
    logic [W-1:0] dd[4];
    item_t        it;
    @(negedge clk);
    rst = r; req_valid = v; d0 = a0; d1 = a1; d2 = a2; d3 = a3; out_ready = ordy;
    dd = '{a0, a1, a2, a3};
    #1;
    for (int i = 0; i < 2; i++) begin
      ld[i]   = (mv[i] == 0) || ordy;
      g[i]    = -1;
      cont[i] = 1'b0;
      if (ld[i] && !r) g[i] = pick(v, mlast[i], mcnt[i], maxb[i], cont[i]);
      exp_rdy = (g[i] >= 0) ? 4'(1 << g[i]) : 4'b0000;
      chk($sformatf("req_ready[%0d]", i), 8'(rdy[i]), 8'(exp_rdy));
      chk($sformatf("out_valid[%0d]", i), 8'(ov[i]), 8'(mv[i] != 0));
      if (g[i] >= 0) begin
        it.sel  = 2'(g[i]);
        it.data = dd[g[i]];
        if (i == 0) q0.push_back(it);
        else        q1.push_back(it);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mv[i] = 0; mlast[i] = 3; mcnt[i] = 0;
        if (i == 0) q0.delete();
        else        q1.delete();
      end else if (ld[i]) begin
        if (g[i] >= 0) begin
          mv[i]    = 1;
          mcnt[i]  = cont[i] ? mcnt[i] + 1 : 1;
          mlast[i] = g[i];
        end else begin
          mv[i]   = 0;
          mcnt[i] = 0;
        end
      end
    end
    if (r) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_valid[%0d]", i), 8'(ov[i]), 8'h00);
        chk($sformatf("rst_data[%0d]", i), 8'(od[i]), 8'h00);
        chk($sformatf("rst_sel[%0d]", i), 8'(os[i]), 8'h00);
      end
    end
  endtask

  task automatic pop_check(input int i);
    item_t e;
    int    sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL underflow[%0d]: handshake of sel %0d with no word expected", i, os[i]);
      return;
    end
    if (i == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("out_sel[%0d]", i), 8'(os[i]), 8'(e.sel));
    chk($sformatf("out_data[%0d]", i), 8'(od[i]), 8'(e.data));
    if (i == 0) acc0.push_back(int'(os[i]));
    else        acc1.push_back(int'(os[i]));
  endtask

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  bit           hold_prev[2] = '{1'b0, 1'b0};
  logic [1:0]   sel_prev[2];
  logic [W-1:0] dat_prev[2];
  initial begin
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (hold_prev[i] && !rst) begin
          chk($sformatf("hold_sel[%0d]", i), 8'(os[i]), 8'(sel_prev[i]));
          chk($sformatf("hold_data[%0d]", i), 8'(od[i]), 8'(dat_prev[i]));
        end
        if (ov[i] && $isunknown(od[i])) chk($sformatf("xdata[%0d]", i), 8'h01, 8'h00);
        if (!rst && ov[i] && out_ready) pop_check(i);
        hold_prev[i] = ov[i] && !out_ready && !rst;
        sel_prev[i]  = os[i];
        dat_prev[i]  = od[i];
      end
    end
  end

  task automatic seq_check(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, 8'(got.size()), 8'(exp.size()));
    for (int k = 0; k < exp.size() && k < got.size(); k++) begin
      chk($sformatf("%s_%0d", name, k), 8'(got[k]), 8'(exp[k]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int           exp_s[$];
    logic [3:0]   v;
    logic [W-1:0] rd[4];
    rst = 1'b1; req_valid = 4'hF; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    for (int i = 0; i < 2; i++) begin mv[i] = 0; mlast[i] = 3; mcnt[i] = 0; end

    // Reset held with every requester asking.
    cycle(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    cycle(1'b1, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);

    // All requesters busy, consumer always ready.
    acc0.delete(); acc1.delete();
    for (int n = 0; n < 10; n++) cycle(1'b0, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD, 1'b1);
    exp_s = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    seq_check("burst2_seq", acc0, exp_s);

    // Backpressure for three cycles, then release.
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b0);
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 1'b1);

    // Lone requester is granted every cycle past its burst limit.
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b0100, 'x, 'x, 4'h7, 'x, 1'b1);

    // Alternating pair from a fresh reset; idle inputs carry X.
    cycle(1'b1, 4'b0000, 'x, 'x, 'x, 'x, 1'b1);
    acc0.delete(); acc1.delete();
    for (int n = 0; n < 5; n++) cycle(1'b0, 4'b1010, 'x, 4'h5, 'x, 4'h9, 1'b1);
    exp_s = '{1, 3, 1, 3};
    seq_check("burst1_seq", acc1, exp_s);

    // Reset while a word is stalled; arbitration restarts at requester 0.
    cycle(1'b0, 4'hF, 4'h6, 4'h7, 4'h8, 4'h9, 1'b0);
    cycle(1'b1, 4'hF, 4'h6, 4'h7, 4'h8, 4'h9, 1'b0);
    acc0.delete(); acc1.delete();
    cycle(1'b0, 4'hF, 4'h6, 4'h7, 4'h8, 4'h9, 1'b1);
    cycle(1'b0, 4'hF, 4'h6, 4'h7, 4'h8, 4'h9, 1'b1);
    chk("restart_sel0", 8'(acc0.size() > 0 ? acc0[0] : 99), 8'h00);
    chk("restart_sel1", 8'(acc1.size() > 0 ? acc1[0] : 99), 8'h00);

    // Random traffic with occasional resets and backpressure.
    for (int n = 0; n < 2000; n++) begin
      v = 4'($urandom);
      for (int k = 0; k < 4; k++) rd[k] = v[k] ? W'($urandom) : 'x;
      cycle(($urandom % 64) == 0, v, rd[0], rd[1], rd[2], rd[3], ($urandom % 4) != 0);
    end
    cycle(1'b0, 4'h0, 'x, 'x, 'x, 'x, 1'b1);
    cycle(1'b0, 4'h0, 'x, 'x, 'x, 'x, 1'b1);
    chk("drain_q0", 8'(q0.size()), 8'h00);
    chk("drain_q1", 8'(q1.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
